// File: rtl/sdhci_pkg.sv
// Shared definitions for the SD host command path: CRC7 polynomial,
// frame geometry and the command transmitter state encoding.
package sdhci_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         FRAME_LEN = 48;
  localparam int         HDR_LEN   = 40;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    DATA = 3'd2,
    CRC  = 3'd3,
    END  = 3'd4
  } cmd_state_e;

endpackage

// File: rtl/sd_crc7_ser.sv
// Serial CRC7 (x^7 + x^3 + 1). Accumulates one bit per enabled cycle,
// then in shift-out mode presents the remainder MSB first on crc_ser_o.
module sd_crc7_ser
  import sdhci_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  input  logic shift_out_i,
  input  logic dat_ser_i,
  output logic crc_ser_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  // Next remainder: clear wins, then feed or plain shift when enabled
  always_comb begin
    crc_d = crc_q;
    fb    = 1'b0;
    if (clr_i) begin
      crc_d = '0;
    end else if (en_i) begin
      if (shift_out_i) begin
        crc_d = {crc_q[5:0], 1'b0};
      end else begin
        fb    = dat_ser_i ^ crc_q[6];
        crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
    end
  end

  // Remainder register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= '0;
    else         crc_q <= crc_d;
  end

  assign crc_ser_o = crc_q[6];

endmodule

// File: rtl/sd_cmd_tx.sv
// SD CMD line transmit sequencer: takes an index/argument over valid/ready
// and serializes the 48-bit command frame, one bit per SD clock strobe.
module sd_cmd_tx
  import sdhci_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_clk_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  input  logic        abort_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        done_o
);

  cmd_state_e          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [HDR_LEN-1:0]  shreg_q, shreg_d;
  logic                cmd_q, cmd_d;
  logic                oe_q, oe_d;
  logic                done_q, done_d;

  logic                crc_feed;
  logic                crc_clr;
  logic                crc_shift;
  logic                crc_bit;

  // Ready only in IDLE and not in the done cycle, so a new command is
  // accepted no earlier than the cycle after done_o.
  assign cmd_ready_o = (state_q == IDLE) && !done_q;
  assign busy_o      = (state_q != IDLE);
  assign cmd_o       = cmd_q;
  assign cmd_oe_o    = oe_q;
  assign done_o      = done_q;

  sd_crc7_ser u_crc (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (crc_feed & sd_clk_en_i),
    .clr_i       (crc_clr),
    .shift_out_i (crc_shift),
    .dat_ser_i   (shreg_q[HDR_LEN-1]),
    .crc_ser_o   (crc_bit)
  );

  // Next-state and output logic; abort overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    cmd_d     = cmd_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    crc_feed  = 1'b0;
    crc_clr   = 1'b0;
    crc_shift = 1'b0;

    if (abort_i) begin
      state_d = IDLE;
      cmd_d   = 1'b1;
      oe_d    = 1'b0;
      crc_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_d = 1'b1;
          oe_d  = 1'b0;
          if (cmd_valid_i && cmd_ready_o) begin
            shreg_d = {2'b01, cmd_index_i, cmd_arg_i};
            crc_clr = 1'b1;
            state_d = ARM;
          end
        end
        ARM: begin
          // Start bit; counter holds the header bits still to go
          if (sd_clk_en_i) begin
            cmd_d    = shreg_q[HDR_LEN-1];
            oe_d     = 1'b1;
            crc_feed = 1'b1;
            shreg_d  = {shreg_q[HDR_LEN-2:0], 1'b0};
            cnt_d    = 6'd39;
            state_d  = DATA;
          end
        end
        DATA: begin
          if (sd_clk_en_i) begin
            cmd_d    = shreg_q[HDR_LEN-1];
            crc_feed = 1'b1;
            shreg_d  = {shreg_q[HDR_LEN-2:0], 1'b0};
            cnt_d    = cnt_q - 6'd1;
            // Counter reaching 0 means bit 8 is on the line now
            if (cnt_q == 6'd1) state_d = CRC;
          end
        end
        CRC: begin
          // Counter runs 0..6 across the seven CRC bits
          if (sd_clk_en_i) begin
            cmd_d     = crc_bit;
            crc_feed  = 1'b1;
            crc_shift = 1'b1;
            if (cnt_q == 6'd6) begin
              cnt_d   = 6'd0;
              state_d = END;
            end else begin
              cnt_d   = cnt_q + 6'd1;
            end
          end
        end
        END: begin
          // First strobe drives the end bit, second releases the line
          if (sd_clk_en_i) begin
            cmd_d = 1'b1;
            if (cnt_q == 6'd0) begin
              cnt_d = 6'd1;
            end else begin
              cnt_d   = 6'd0;
              oe_d    = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cmd_d   = 1'b1;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counter, shift register and registered pad outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      cmd_q   <= 1'b1;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      cmd_q   <= cmd_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: captures the serialized CMD frame on
// strobe cycles and compares it with hand-computed frames.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_clk_en;
  logic        cmd_valid;
  logic        cmd_ready_o;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        abort;
  logic        cmd_o;
  logic        cmd_oe_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  localparam int STB_RANDOM = 100;
  int stb_mode = 0;
  int gap = 0;

  // Monitor state
  logic        stb_seen = 1'b0;
  logic        abort_seen = 1'b0;
  logic        frame_active = 1'b0;
  logic [47:0] frame = '0;
  logic [47:0] last_frame = '0;
  int          bitcnt = 0;
  int          stbcnt = 0;
  int          last_bits = 0;
  int          last_stb = 0;
  int          done_cnt = 0;
  int          nostb_viol = 0;
  logic        last_cmd = 1'b1;

  sd_cmd_tx dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sd_clk_en_i (sd_clk_en),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .cmd_index_i (cmd_index),
    .cmd_arg_i   (cmd_arg),
    .abort_i     (abort),
    .cmd_o       (cmd_o),
    .cmd_oe_o    (cmd_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  // Strobe generator: off, every N clocks, or random 1..7 spacing
  always @(posedge clk) begin
    #1;
    if (stb_mode == 0) begin
      sd_clk_en = 1'b0;
      gap = 0;
    end else if (gap <= 1) begin
      sd_clk_en = 1'b1;
      gap = (stb_mode == STB_RANDOM) ? int'($urandom_range(1, 7)) : stb_mode;
    end else begin
      sd_clk_en = 1'b0;
      gap = gap - 1;
    end
  end

  // Record what the DUT saw at the active edge
  always @(posedge clk) begin
    stb_seen   = sd_clk_en;
    abort_seen = abort;
  end

  // Frame capture, strobe counting and done tracking
  always @(negedge clk) begin
    if (!stb_seen && !abort_seen && cmd_o !== last_cmd) nostb_viol++;
    last_cmd = cmd_o;
    if (stb_seen && cmd_oe_o) begin
      if (!frame_active) begin
        frame_active = 1'b1;
        frame  = {47'b0, cmd_o};
        bitcnt = 1;
        stbcnt = 1;
      end else begin
        frame  = {frame[46:0], cmd_o};
        bitcnt++;
        stbcnt++;
      end
    end
    if (!cmd_oe_o) begin
      if (done_o) begin
        if (frame_active && stb_seen) stbcnt++;
        done_cnt++;
        last_frame = frame;
        last_bits  = bitcnt;
        last_stb   = stbcnt;
      end
      frame_active = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [6:0]  c;
    logic        fb;
    hdr = {2'b01, idx, arg};
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = hdr[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {hdr, c, 1'b1};
  endfunction

  int acc_done = 0;

  // Present a command and hold it until ready is seen (bounded)
  task automatic send(input logic [5:0] idx, input logic [31:0] arg);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    while (!got && n < 2000) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1'b1;
        acc_done = done_cnt;
      end
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("accept", {63'b0, got}, 64'd1);
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done_cnt - base, 64'd1);
  endtask

  int base;
  int idle_bad;
  logic [5:0]  r_idx;
  logic [31:0] r_arg;

  initial begin
    rst_n     = 1'b0;
    sd_clk_en = 1'b0;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    abort     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd",   cmd_o,       1);
    check("rst_oe",    cmd_oe_o,    0);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_busy",  busy_o,      0);
    check("rst_done",  done_o,      0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle without strobes
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (cmd_o !== 1'b1 || cmd_oe_o !== 1'b0 || cmd_ready_o !== 1'b1) idle_bad++;
    end
    check("idle_hold", idle_bad, 0);

    // CMD0, strobe every 4 clk
    stb_mode = 4;
    base = done_cnt;
    send(6'd0, 32'h0);
    @(negedge clk);
    check("ready_low", cmd_ready_o, 0);
    check("busy_high", busy_o, 1);
    wait_done(base);
    check("cmd0_frame", last_frame, 48'h40_0000_0000_95);
    check("cmd0_bits",  last_bits, 48);
    check("cmd0_stb",   last_stb, 49);
    repeat (20) @(negedge clk);
    check("cmd0_done_once", done_cnt - base, 1);

    // CMD8, continuous strobe
    stb_mode = 1;
    base = done_cnt;
    send(6'd8, 32'h0000_01AA);
    wait_done(base);
    check("cmd8_frame", last_frame, 48'h48_0000_01AA_87);
    check("cmd8_stb",   last_stb, 49);

    // CMD55 followed immediately by CMD0
    stb_mode = 3;
    base = done_cnt;
    send(6'd55, 32'h0);
    send(6'd0, 32'h0);
    check("b2b_after_done", acc_done - base, 1);
    check("cmd55_crc",   last_frame[7:0], 8'h65);
    check("cmd55_frame", last_frame, 48'h77_0000_0000_65);
    wait_done(base + 1);
    check("b2b_cmd0_frame", last_frame, 48'h40_0000_0000_95);

    // Abort in mid-DATA (around bit 20)
    stb_mode = 2;
    base = done_cnt;
    send(6'd17, 32'hDEAD_BEEF);
    for (int n = 0; n < 1000 && !(frame_active && bitcnt >= 20); n++) @(negedge clk);
    check("abort_data_reached", bitcnt, 20);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_data_oe",   cmd_oe_o, 0);
    check("abort_data_cmd",  cmd_o, 1);
    check("abort_data_busy", busy_o, 0);
    repeat (30) @(negedge clk);
    check("abort_data_nodone", done_cnt - base, 0);

    // Abort in mid-CRC
    send(6'd2, 32'h1234_5678);
    for (int n = 0; n < 1000 && !(frame_active && bitcnt >= 43); n++) @(negedge clk);
    check("abort_crc_reached", bitcnt, 43);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_crc_oe",  cmd_oe_o, 0);
    check("abort_crc_cmd", cmd_o, 1);
    repeat (30) @(negedge clk);
    check("abort_crc_nodone", done_cnt - base, 0);

    // Abort together with a handshake: command must not be taken
    stb_mode = 1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_index = 6'd0; cmd_arg = 32'h0; abort = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_hs_busy", busy_o, 0);
    check("abort_hs_oe",   cmd_oe_o, 0);

    // CMD0 after aborts
    send(6'd0, 32'h0);
    wait_done(base);
    check("post_abort_frame", last_frame, 48'h40_0000_0000_95);

    // Random strobe spacing against the reference frame
    stb_mode = STB_RANDOM;
    for (int k = 0; k < 3; k++) begin
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      base = done_cnt;
      send(r_idx, r_arg);
      wait_done(base);
      check("rand_frame", last_frame, ref_frame(r_idx, r_arg));
      check("rand_stb",   last_stb, 49);
    end
    check("nostb_change", nostb_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
